migration_ring_node: RTL

- Downstream companion of the per-cell position-update stage. It consumes emigrant particles (new pos/vel/cell) that the updater emits when a particle leaves its cell. It forwards them around a unidirectional inter-cell ring.
- It delivers ring traffic addressed to its own cell into the updater's nodePosIn/nodeVelIn/nodeCellIn inputs.
- It also provides a quiet indication used for migration-phase completion.
- All data uses the codebase null encoding: MSB set = empty slot.

---
 rtl/migration_ring_node.sv | 74 +++++++
 1 files changed

// File: rtl/migration_ring_node.sv
// migration_ring_node: injects emigrant particles onto a unidirectional cell ring and delivers ring traffic addressed to this cell.
module migration_ring_node #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4,
  parameter int QUIET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [32:0]      cell_id,
  input  logic [96:0]      upd_pos_in,
  input  logic [96:0]      upd_vel_in,
  input  logic [32:0]      upd_cell_in,
  input  logic [1:0]       upd_block,
  input  logic [96:0]      ring_pos_in,
  input  logic [96:0]      ring_vel_in,
  input  logic [32:0]      ring_cell_in,
  output logic [96:0]      ring_pos_out,
  output logic [96:0]      ring_vel_out,
  output logic [32:0]      ring_cell_out,
  output logic [96:0]      loc_pos_out,
  output logic [96:0]      loc_vel_out,
  output logic [32:0]      loc_cell_out,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_full,
  output logic             drop_err,
  output logic             quiet
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(QUIET + 1);
  localparam logic [96:0] NULL_PV = {1'b1, 96'b0};
  localparam logic [32:0] NULL_C  = {1'b1, 32'b0};
  logic [226:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [QW-1:0]  idle_cnt;
  logic [226:0]   head, ring_trip;
  logic           ring_valid, deliver, through, pop, push, wr, drop, idle;
  always_comb begin
    ring_valid = !ring_cell_in[32];
    deliver    = ring_valid && ring_cell_in == cell_id && upd_block == 2'b00;
    through    = ring_valid && !deliver;
    pop        = !through && fifo_count != '0;
    push       = !upd_cell_in[32];
    wr         = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
    head       = mem[rd_ptr];
    ring_trip  = {ring_pos_in, ring_vel_in, ring_cell_in};
    idle       = ring_cell_in[32] && upd_cell_in[32] && fifo_count == '0
                 && ring_cell_out[32] && loc_cell_out[32];
  end
  assign fifo_full = fifo_count == CNT_W'(DEPTH);
  assign quiet     = idle && idle_cnt == QW'(QUIET);
  // Storage needs no reset: the pointers and count define what is buffered.
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {upd_pos_in, upd_vel_in, upd_cell_in};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {ring_pos_out, ring_vel_out, ring_cell_out} <= {NULL_PV, NULL_PV, NULL_C};
      {loc_pos_out, loc_vel_out, loc_cell_out}    <= {NULL_PV, NULL_PV, NULL_C};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_err   <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      {ring_pos_out, ring_vel_out, ring_cell_out} <= through ? ring_trip : pop ? head : {NULL_PV, NULL_PV, NULL_C};
      {loc_pos_out, loc_vel_out, loc_cell_out}    <= deliver ? ring_trip : {NULL_PV, NULL_PV, NULL_C};
      wr_ptr     <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_count <= fifo_count + CNT_W'(wr) - CNT_W'(pop);
      drop_err   <= drop_err | drop;
      idle_cnt   <= !idle ? '0 : idle_cnt == QW'(QUIET) ? idle_cnt : idle_cnt + 1'b1;
    end
  end
endmodule
